branch_resolve_bht: RTL and testbench

- Next-generation branch unit for the 5-stage MIPS core.
- Evaluates branch conditions in EX and detects mispredicts against a parametrised table of 2-bit saturating counters (BHT).
- Issues a registered redirect to IF.
- The IF stage reads the BHT combinationally on the fetch PC.
- EX resolves the branch and trains the BHT one cycle later.

---
 rtl/branch_resolve_bht.sv | 171 +++++++++++++++++
 tb/tb_branch_resolve_bht.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: EX-stage branch resolution with a table of 2-bit
// saturating counters (BHT) for IF prediction.
// IF looks up pred_pc combinationally. EX resolves a branch, issues a
// registered redirect on a mispredict (or always for j/jr), and trains
// the BHT on the same clock edge.
// Optional build macro BRANCH_STATS_EN adds branch and mispredict counters.
module branch_resolve_bht #(
  parameter int         DATA_W    = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pred_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [2:0]        res_op,
  input  logic [31:0]       res_pc,
  input  logic [DATA_W-1:0] res_opa,
  input  logic [DATA_W-1:0] res_opb,
  input  logic              res_pred_taken,
  input  logic [31:0]       res_target,
  input  logic [31:0]       res_fallthru,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              res_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;

  // Actual branch outcome; j (110) and jr (111) are always taken.
  function automatic logic f_cond(input logic [2:0]               op,
                                  input logic signed [DATA_W-1:0] a,
                                  input logic signed [DATA_W-1:0] b);
    logic sign;
    logic blez;
    sign = (a < 0);
    blez = sign | (a == '0);
    case (op)
      OP_BEQ:  f_cond = (a == b);
      OP_BNE:  f_cond = (a != b);
      OP_BLEZ: f_cond = blez;
      OP_BGTZ: f_cond = ~blez;
      OP_BLTZ: f_cond = sign;
      OP_BGEZ: f_cond = ~sign;
      default: f_cond = 1'b1;
    endcase
  endfunction

  // Next counter value: saturate at 2'b11 on taken and at 2'b00 on not-taken.
  function automatic logic [1:0] f_sat_cnt(input logic [1:0] cnt, input logic taken);
    if (taken)
      f_sat_cnt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else
      f_sat_cnt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  logic [1:0]  r_bht [BHT_DEPTH];
  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_res_taken;

  logic                     w_accept;
  logic                     w_is_jump;
  logic                     w_actual;
  logic                     w_mis;
  logic                     w_train;
  logic [IDX_W-1:0]         w_lkp_idx;
  logic [IDX_W-1:0]         w_upd_idx;
  logic [31:0]              w_jr_tgt;
  logic signed [DATA_W-1:0] w_opa_s;
  logic signed [DATA_W-1:0] w_opb_s;
  logic                     w_unused_bits;

  // jr target is rs, truncated or zero-extended to 32 bits.
  if (DATA_W >= 32) begin : g_jr_trunc
    assign w_jr_tgt = res_opa[31:0];
  end else begin : g_jr_zext
    assign w_jr_tgt = {{(32-DATA_W){1'b0}}, res_opa};
  end

  // Word-aligned PCs: bits [1:0] and bits above the index alias by design.
  assign w_unused_bits = ^{pred_pc[1:0], pred_pc[31:IDX_W+2],
                           res_pc[1:0], res_pc[31:IDX_W+2]};

  assign w_opa_s   = res_opa;
  assign w_opb_s   = res_opb;
  assign w_lkp_idx = pred_pc[IDX_W+1:2];
  assign w_upd_idx = res_pc[IDX_W+1:2];

  // Prediction reads the stored counter with no bypass from a same-cycle update.
  assign pred_taken = r_bht[w_lkp_idx][1];

  // The instruction in EX while redirect is high is wrong-path and is dropped.
  assign w_accept  = res_valid & ~r_redirect;
  assign w_is_jump = (res_op[2:1] == 2'b11);
  assign w_actual  = f_cond(res_op, w_opa_s, w_opb_s);
  assign w_mis     = w_actual ^ res_pred_taken;
  assign w_train   = w_accept & ~w_is_jump;

  // ---- EX -> IF boundary: registered redirect and outcome ----
  // Redirect on mispredict or any jump; hold pc/outcome when nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'h0;
      r_res_taken   <= 1'b0;
    end else if (w_accept) begin
      if (w_is_jump) begin
        r_redirect    <= 1'b1;
        r_redirect_pc <= res_op[0] ? w_jr_tgt : res_target;
        r_res_taken   <= 1'b1;
      end else begin
        r_redirect    <= w_mis;
        r_redirect_pc <= w_actual ? res_target : res_fallthru;
        r_res_taken   <= w_actual;
      end
    end else begin
      r_redirect <= 1'b0;
    end
  end

  // BHT training for accepted conditional branches, committed with the redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= CNT_INIT;
      end
    end else if (w_train) begin
      r_bht[w_upd_idx] <= f_sat_cnt(r_bht[w_upd_idx], w_actual);
    end
  end

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign res_taken   = r_res_taken;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  // Count accepted conditional branches and their mispredicts; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= 32'h0;
      r_stat_mispredicts <= 32'h0;
    end else if (w_train) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (w_mis) begin
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed testbench for branch_resolve_bht with hand-computed expectations.
module tb_branch_resolve_bht;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [2:0]  res_op;
  logic [31:0] res_pc;
  logic [31:0] res_opa;
  logic [31:0] res_opb;
  logic        res_pred_taken;
  logic [31:0] res_target;
  logic [31:0] res_fallthru;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        res_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int n_vec;
  int n_err;

  branch_resolve_bht dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_op         (res_op),
    .res_pc         (res_pc),
    .res_opa        (res_opa),
    .res_opb        (res_opb),
    .res_pred_taken (res_pred_taken),
    .res_target     (res_target),
    .res_fallthru   (res_fallthru),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .res_taken      (res_taken)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] a,
                    input logic [31:0] b, input logic pred, input logic [31:0] tgt);
    res_valid      = 1'b1;
    res_op         = op;
    res_pc         = pc;
    res_opa        = a;
    res_opb        = b;
    res_pred_taken = pred;
    res_target     = tgt;
    res_fallthru   = pc + 32'd4;
  endtask

  task automatic idle();
    res_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    chk(tag, {31'b0, pred_taken}, {31'b0, exp});
  endtask

  task automatic out3(input string tag, input logic rd, input logic [31:0] rpc, input logic tk);
    chk({tag, ".redirect"}, {31'b0, redirect}, {31'b0, rd});
    chk({tag, ".redirect_pc"}, redirect_pc, rpc);
    chk({tag, ".res_taken"}, {31'b0, res_taken}, {31'b0, tk});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    pred_pc = 32'h0;
    res_valid = 1'b0;
    res_op = 3'b000;
    res_pc = 32'h0;
    res_opa = 32'h0;
    res_opb = 32'h0;
    res_pred_taken = 1'b0;
    res_target = 32'h0;
    res_fallthru = 32'h0;

    // Reset state and full lookup sweep
    #3;
    out3("reset", 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) look("reset.sweep", i * 4, 1'b0);
    step();

    // beq mispredict: taken, predicted not-taken
    br(3'b000, 32'h100, 32'd5, 32'd5, 1'b0, 32'h400);
    step();
    out3("beq_mis", 1'b1, 32'h400, 1'b1);
    idle();
    look("beq_mis.bht", 32'h100, 1'b1);
    step();
    chk("beq_mis.drop", {31'b0, redirect}, 32'd0);

    // Signed compares
    br(3'b100, 32'h204, 32'h8000_0000, 32'h0, 1'b1, 32'h280);
    step();
    out3("bltz_neg", 1'b0, 32'h280, 1'b1);
    br(3'b011, 32'h208, 32'h8000_0000, 32'h0, 1'b1, 32'h300);
    step();
    out3("bgtz_neg", 1'b1, 32'h20c, 1'b0);
    idle();
    step();
    chk("bgtz_neg.drop", {31'b0, redirect}, 32'd0);
    look("bltz.bht", 32'h204, 1'b1);
    look("bgtz.bht", 32'h208, 1'b0);

    // Saturation on a single entry (predictions match, so no redirects)
    pred_pc = 32'h310;
    for (int i = 0; i < 3; i++) begin
      br(3'b000, 32'h310, 32'd7, 32'd7, 1'b1, 32'h600);
      step();
      out3("sat_t", 1'b0, 32'h600, 1'b1);
      look("sat_t.bht", 32'h310, 1'b1);
    end
    br(3'b001, 32'h310, 32'd7, 32'd7, 1'b0, 32'h600);
    step();
    out3("sat_n1", 1'b0, 32'h314, 1'b0);
    look("sat_n1.bht", 32'h310, 1'b1);
    step();
    look("sat_n2.bht", 32'h310, 1'b0);
    step();
    look("sat_n3.bht", 32'h310, 1'b0);
    step();
    look("sat_n4.bht", 32'h310, 1'b0);
    br(3'b000, 32'h310, 32'd7, 32'd7, 1'b1, 32'h600);
    step();
    look("sat_up1.bht", 32'h310, 1'b0);
    step();
    look("sat_up2.bht", 32'h310, 1'b1);

    // Shadow cycle: branch in EX while redirect is high is ignored
    br(3'b000, 32'h414, 32'd1, 32'd2, 1'b1, 32'h700);
    step();
    out3("shadow_mis", 1'b1, 32'h418, 1'b0);
    br(3'b001, 32'h420, 32'd1, 32'd2, 1'b0, 32'h500);
    step();
    out3("shadow_ign", 1'b0, 32'h418, 1'b0);
    idle();
    look("shadow.bht", 32'h420, 1'b0);
    look("shadow_mis.bht", 32'h414, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, 32'd13);
    chk("stat_mispredicts", stat_mispredicts, 32'd3);
`endif

    // Jumps: always redirect, never train
    br(3'b111, 32'h420, 32'h1234, 32'h0, 1'b0, 32'h999);
    step();
    out3("jr", 1'b1, 32'h1234, 1'b1);
    idle();
    step();
    chk("jr.drop", {31'b0, redirect}, 32'd0);
    look("jr.bht", 32'h420, 1'b0);
    br(3'b110, 32'h424, 32'h0, 32'h0, 1'b0, 32'h888);
    step();
    out3("j", 1'b1, 32'h888, 1'b1);
    idle();

    // Asynchronous reset between edges while redirect is high
    #2;
    rst = 1'b1;
    #1;
    out3("async_rst", 1'b0, 32'h0, 1'b0);
`ifdef BRANCH_STATS_EN
    chk("rst.stat_branches", stat_branches, 32'd0);
    chk("rst.stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    for (int i = 0; i < 64; i++) look("rst.sweep", i * 4, 1'b0);
    rst = 1'b0;
    step();
    // Entry 2 was 00 before reset; back at 01 one taken makes it predict taken
    br(3'b000, 32'h208, 32'd3, 32'd3, 1'b1, 32'h300);
    step();
    idle();
    look("rst.cnt_init", 32'h208, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
